// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: address/data phase pipeline, programmable wait states,
// byte-laned sized accesses to a word array and the two-cycle ERROR response.
module ahb_slave_mem #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [2:0]            Hburst,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready_in,
    output logic                  Hready_out,
    output logic                  Hresp,
    output logic [DATA_WIDTH-1:0] Hrdata
);

    localparam int unsigned     ByteW    = DATA_WIDTH / 8;
    localparam int unsigned     LaneW    = $clog2(ByteW);
    localparam int unsigned     IdxW     = $clog2(MEM_DEPTH);
    localparam longint unsigned MemBytes = longint'(MEM_DEPTH) * ByteW;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StComplete,
        StErr1,
        StErr2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [LaneW-1:0]   lane_q, lane_d;
    logic [2:0]         size_q, size_d;
    logic               write_q, write_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic [7:0]            size_mask;
    logic                  illegal;
    logic                  accept;
    logic [ByteW-1:0]      lane_we;

    // Each beat is decoded on its own; the burst type carries no information here.
    logic unused_hburst;
    assign unused_hburst = ^Hburst;

    // Address-phase decode: acceptance and legality of the presented transfer.
    always_comb begin
        offset    = Haddr - BASE_ADDR;
        size_mask = 8'((9'd1 << Hsize) - 9'd1);
        illegal   = (Haddr < BASE_ADDR) ||
                    (64'(offset) >= MemBytes) ||
                    (|(Haddr[7:0] & size_mask)) ||
                    (Hsize > 3'(LaneW));
        accept    = Hsel && Hready_in && Htrans[1];
    end

    // Next-state logic: wait countdown, error pair, and back-to-back acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StComplete;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1: state_d = StErr2;
            default: begin
                // StIdle, StComplete and StErr2 all end a data phase and can take a new one.
                if (accept) begin
                    idx_d   = offset[LaneW +: IdxW];
                    lane_d  = offset[LaneW-1:0];
                    size_d  = Hsize;
                    write_d = Hwrite;
                    if (illegal) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StComplete;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Control state register; reset abandons any pending write.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Byte-lane enables for a write completing this cycle.
    always_comb begin
        for (int i = 0; i < ByteW; i++) begin
            lane_we[i] = (state_q == StComplete) && write_q &&
                         (i >= int'(lane_q)) && (i < int'(lane_q) + (1 << size_q));
        end
    end

    // Array write on the COMPLETE edge. Committing here means an overlapping read of the
    // same word reads the array one cycle later and already sees the new bytes.
    always_ff @(posedge hclk) begin
        for (int i = 0; i < ByteW; i++) begin
            if (lane_we[i]) begin
                mem_q[idx_q][8*i +: 8] <= Hwdata[8*i +: 8];
            end
        end
    end

    // Response outputs are pure functions of the state; read data only in a read COMPLETE.
    always_comb begin
        Hready_out = !((state_q == StWait) || (state_q == StErr1));
        Hresp      = (state_q == StErr1) || (state_q == StErr2);
        Hrdata     = '0;
        if ((state_q == StComplete) && !write_q) begin
            Hrdata = mem_q[idx_q];
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized bench: two slaves (zero-wait at base 0, three-wait at base 0x100) share one
// bus; a byte-addressed memory model predicts every response and read word.
module tb_ahb_slave_mem;

    localparam int unsigned MemBytes = 256;
    localparam logic [31:0] Base0    = 32'h0;
    localparam logic [31:0] Base1    = 32'h100;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          acc;
        bit          err;
        int          waits;
    } txn_t;

    logic        hclk;
    logic        hresetn;
    logic        sel0, sel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready0, hresp0, hready1, hresp1;
    logic [31:0] hrdata0, hrdata1;
    logic        hready_in0, hready_in1;

    // Single-slave style: bus HREADY is each slave's own ready.
    assign hready_in0 = hready0;
    assign hready_in1 = hready1;

    int   n_checks;
    int   n_fail;
    int   cur;
    txn_t q[$];
    logic [7:0] mem_m [2][MemBytes];

    ahb_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .BASE_ADDR(Base0), .WAIT_STATES(0)
    ) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .Hsel(sel0), .Haddr(haddr), .Htrans(htrans),
        .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Hwdata(hwdata),
        .Hready_in(hready_in0), .Hready_out(hready0), .Hresp(hresp0), .Hrdata(hrdata0)
    );

    ahb_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .BASE_ADDR(Base1), .WAIT_STATES(3)
    ) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .Hsel(sel1), .Haddr(haddr), .Htrans(htrans),
        .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Hwdata(hwdata),
        .Hready_in(hready_in1), .Hready_out(hready1), .Hresp(hresp1), .Hrdata(hrdata1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input int dut);
        return (dut == 0) ? Base0 : Base1;
    endfunction

    function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [31:0] base);
        longint a = longint'(addr);
        longint b = longint'(base);
        longint n = longint'(1) << size;
        if (a < b) return 1'b0;
        if (a - b >= longint'(MemBytes)) return 1'b0;
        if (a % n != 0) return 1'b0;
        if (n > 4) return 1'b0;
        return 1'b1;
    endfunction

    function automatic txn_t mk(input int dut, input bit sel, input logic [1:0] trans,
                                input bit write, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.sel   = sel;
        t.trans = trans;
        t.write = write;
        t.size  = size;
        t.addr  = addr;
        t.wdata = wdata;
        t.acc   = sel && (trans >= 2'd2);
        t.err   = t.acc && !is_legal(addr, size, base_of(dut));
        t.waits = !t.acc ? 0 : (t.err ? 1 : ((dut == 0) ? 0 : 3));
        return t;
    endfunction

    function automatic txn_t rand_txn(input int dut);
        logic [31:0] base = base_of(dut);
        int unsigned k    = $urandom_range(0, 99);
        int unsigned m    = $urandom_range(0, 19);
        int unsigned off  = $urandom_range(0, MemBytes - 1);
        logic [2:0]  sz   = ($urandom_range(0, 14) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        logic [1:0]  tr   = (k < 10) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        logic [31:0] addr;
        if (m == 0)      addr = base + MemBytes + $urandom_range(0, 15);
        else if (m == 1) addr = base - $urandom_range(1, 16);
        else if (m <= 3) addr = base + off;
        else             addr = base + (off & ~((32'd1 << sz) - 32'd1));
        return mk(dut, k >= 4, tr, 1'($urandom_range(0, 1)), sz, addr, $urandom);
    endfunction

    function automatic logic [31:0] model_word(input int dut, input logic [31:0] addr);
        int unsigned off = int'(addr - base_of(dut));
        int unsigned w   = off - off % 4;
        return {mem_m[dut][w+3], mem_m[dut][w+2], mem_m[dut][w+1], mem_m[dut][w]};
    endfunction

    task automatic model_write(input int dut, input txn_t t);
        int unsigned off = int'(t.addr - base_of(dut));
        for (int i = 0; i < (1 << t.size); i++) begin
            mem_m[dut][off + i] = t.wdata[8 * ((off + i) % 4) +: 8];
        end
    endtask

    task automatic drive(input txn_t t);
        sel0   = (cur == 0) && t.sel;
        sel1   = (cur == 1) && t.sel;
        htrans = t.trans;
        hwrite = t.write;
        hsize  = t.size;
        haddr  = t.addr;
        hburst = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_idle();
        sel0   = 1'b0;
        sel1   = 1'b0;
        htrans = 2'd0;
    endtask

    // Pipelined master: the head of the queue sits on the bus and is taken on the next
    // edge where the slave is ready; the transfer before it is then in its data phase.
    task automatic run_q(input int dut);
        int          budget = 20000;
        int          waits  = 0;
        bit          d_v    = 1'b0;
        txn_t        d;
        logic        r, rs;
        logic [31:0] rd;
        cur = dut;
        while ((q.size() > 0 || d_v) && budget > 0) begin
            @(negedge hclk);
            budget--;
            r  = (dut == 0) ? hready0 : hready1;
            rs = (dut == 0) ? hresp0 : hresp1;
            rd = (dut == 0) ? hrdata0 : hrdata1;
            if (d_v) begin
                if (!r) begin
                    waits++;
                    check_eq("wait_resp", 64'(rs), 64'(d.err));
                    check_eq("wait_rdata", 64'(rd), 64'(0));
                end else begin
                    check_eq("resp", 64'(rs), 64'(d.err));
                    check_eq("waits", 64'(waits), 64'(d.waits));
                    if (d.acc && !d.err) begin
                        if (d.write) model_write(dut, d);
                        else check_eq("rdata", 64'(rd), 64'(model_word(dut, d.addr)));
                    end else begin
                        check_eq("rdata_zero", 64'(rd), 64'(0));
                    end
                    d_v = 1'b0;
                end
            end
            if (r) begin
                if (q.size() > 0) begin
                    d     = q.pop_front();
                    d_v   = 1'b1;
                    waits = 0;
                    drive(d);
                end else begin
                    drive_idle();
                end
            end
            @(posedge hclk);
            #1;
            if (d_v) hwdata = d.wdata;
            if (q.size() > 0) drive(q[0]);
            else drive_idle();
        end
        check_eq("drain", 64'(q.size() + int'(d_v)), 64'(0));
    endtask

    task automatic fill(input int dut);
        for (int i = 0; i < 64; i++) begin
            q.push_back(mk(dut, 1, 2'd2, 1, 3'd2, base_of(dut) + 32'(4 * i), $urandom));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur      = 0;
        hresetn  = 1'b0;
        hwdata   = '0;
        hburst   = '0;
        haddr    = '0;
        hwrite   = 1'b0;
        hsize    = '0;
        drive_idle();
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check_eq("rst_ready0", 64'(hready0), 64'(1));
        check_eq("rst_resp0", 64'(hresp0), 64'(0));
        check_eq("rst_rdata0", 64'(hrdata0), 64'(0));
        check_eq("rst_ready1", 64'(hready1), 64'(1));
        check_eq("rst_resp1", 64'(hresp1), 64'(0));
        check_eq("rst_rdata1", 64'(hrdata1), 64'(0));
        hresetn = 1'b1;

        // Zero-wait slave.
        fill(0);
        q.push_back(mk(0, 1, 2'd0, 0, 3'd2, 32'h10, 0));
        q.push_back(mk(0, 1, 2'd1, 1, 3'd2, 32'h14, 0));
        q.push_back(mk(0, 0, 2'd2, 1, 3'd2, 32'h18, 32'h5555_5555));
        q.push_back(mk(0, 1, 2'd2, 1, 3'd2, 32'h10, 32'hDEAD_BEEF));
        q.push_back(mk(0, 1, 2'd2, 0, 3'd2, 32'h10, 0));
        q.push_back(mk(0, 1, 2'd2, 1, 3'd2, 32'h20, 32'h1122_3344));
        q.push_back(mk(0, 1, 2'd3, 1, 3'd0, 32'h21, 32'h0000_AA00));
        q.push_back(mk(0, 1, 2'd3, 1, 3'd1, 32'h22, 32'hBBCC_0000));
        q.push_back(mk(0, 1, 2'd2, 0, 3'd2, 32'h20, 0));
        q.push_back(mk(0, 1, 2'd2, 0, 3'd2, 32'h100, 0));
        q.push_back(mk(0, 1, 2'd2, 0, 3'd2, 32'h2, 0));
        q.push_back(mk(0, 1, 2'd2, 1, 3'd2, 32'h12, 32'hFFFF_FFFF));
        q.push_back(mk(0, 1, 2'd2, 1, 3'd3, 32'h10, 32'hFFFF_FFFF));
        q.push_back(mk(0, 1, 2'd2, 0, 3'd2, 32'h10, 0));
        for (int i = 0; i < 300; i++) q.push_back(rand_txn(0));
        run_q(0);

        // Three-wait slave at a non-zero base.
        fill(1);
        q.push_back(mk(1, 1, 2'd2, 0, 3'd2, Base1 + 32'h10, 0));
        q.push_back(mk(1, 1, 2'd2, 0, 3'd2, Base1 + 32'h14, 0));
        q.push_back(mk(1, 1, 2'd2, 1, 3'd2, Base1 + 32'h18, 32'hA5A5_0F0F));
        q.push_back(mk(1, 1, 2'd2, 0, 3'd2, Base1 + 32'h18, 0));
        q.push_back(mk(1, 1, 2'd2, 0, 3'd2, Base1 + 32'h100, 0));
        q.push_back(mk(1, 1, 2'd2, 1, 3'd2, Base1 - 32'h4, 32'h1234_5678));
        q.push_back(mk(1, 1, 2'd2, 0, 3'd2, Base1 + 32'h2, 0));
        q.push_back(mk(1, 1, 2'd2, 0, 3'd2, Base1 + 32'h18, 0));
        for (int i = 0; i < 150; i++) q.push_back(rand_txn(1));
        run_q(1);

        // Reset arriving while a write waits: outputs drop to reset values at once and
        // the target word keeps its old content.
        cur = 1;
        @(negedge hclk);
        drive(mk(1, 1, 2'd2, 1, 3'd2, Base1 + 32'h20, 32'hCAFE_F00D));
        @(posedge hclk);
        #1;
        drive_idle();
        hwdata = 32'hCAFE_F00D;
        check_eq("rst_pre_wait", 64'(hready1), 64'(0));
        #2;
        hresetn = 1'b0;
        #1;
        check_eq("rst_mid_ready", 64'(hready1), 64'(1));
        check_eq("rst_mid_resp", 64'(hresp1), 64'(0));
        check_eq("rst_mid_rdata", 64'(hrdata1), 64'(0));
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        q.push_back(mk(1, 1, 2'd2, 0, 3'd2, Base1 + 32'h20, 0));
        run_q(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
